window_mac: RTL and testbench

WINDOW_MAC -- requirements
Module: window_mac

---
 rtl/window_mac_pkg.sv | 25 ++
 rtl/window_mac_if.sv | 37 +++
 rtl/window_mac_mac_lane.sv | 47 ++++
 rtl/window_mac.sv | 109 ++++++++++
 tb/tb_window_mac.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/window_mac_pkg.sv
// Shared types and width helpers for the window MAC and its upstream memory stage.
package window_mac_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StHold
  } state_e;

  localparam int unsigned DefImageWidth = 8;

  // Width of kernel_dim for a given image row length.
  function automatic int unsigned kdim_width(int unsigned image_width);
    return (image_width > 1) ? $clog2(image_width) : 1;
  endfunction

  // Width of a tap index / weight-store address (store holds image_width^2 entries).
  function automatic int unsigned tap_width(int unsigned image_width);
    return (image_width > 1) ? $clog2(image_width * image_width) : 1;
  endfunction

  localparam int unsigned DefKdimWidth = kdim_width(DefImageWidth);
  localparam int unsigned DefTapWidth  = tap_width(DefImageWidth);

endpackage

// File: rtl/window_mac_if.sv
// Control, weight-load, pixel-stream and result handshake signals of the window MAC.
interface window_mac_if #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned IMAGE_WIDTH = 8,
  parameter int unsigned NUM_UNITS   = 2,
  parameter int unsigned ACC_WIDTH   = 40
);
  import window_mac_pkg::*;

  localparam int unsigned KW = kdim_width(IMAGE_WIDTH);
  localparam int unsigned TW = tap_width(IMAGE_WIDTH);

  logic                                  start;
  logic [KW-1:0]                         kernel_dim;
  logic                                  w_we;
  logic [TW-1:0]                         w_addr;
  logic [DATA_WIDTH-1:0]                 w_data;
  logic                                  in_valid;
  logic [NUM_UNITS-1:0][DATA_WIDTH-1:0]  in_data;
  logic                                  step;
  logic                                  out_valid;
  logic                                  out_ready;
  logic [NUM_UNITS-1:0][ACC_WIDTH-1:0]   out_data;
  logic                                  busy;
  logic                                  done;

  modport master (
    output start, kernel_dim, w_we, w_addr, w_data, in_valid, in_data, out_ready,
    input  step, out_valid, out_data, busy, done
  );

  modport slave (
    input  start, kernel_dim, w_we, w_addr, w_data, in_valid, in_data, out_ready,
    output step, out_valid, out_data, busy, done
  );

endinterface

// File: rtl/window_mac_mac_lane.sv
// One lane's signed multiply-accumulate with synchronous clear; wraps modulo 2^ACC_WIDTH.
module mac_lane #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ACC_WIDTH  = 40
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_i,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] pixel_i,
  input  logic [DATA_WIDTH-1:0] weight_i,
  output logic [ACC_WIDTH-1:0]  acc_o
);

  localparam int unsigned ProdW = 2 * DATA_WIDTH;
  localparam int unsigned ExtW  = (ProdW > ACC_WIDTH) ? ProdW : ACC_WIDTH;

  logic signed [ProdW-1:0] prod;
  logic signed [ExtW-1:0]  prod_ext;
  logic [ExtW-1:0]         sum;
  logic [ACC_WIDTH-1:0]    acc_q, acc_d;

  // Full-precision signed product, sign-extended before the wrapping add.
  always_comb begin
    prod     = $signed(pixel_i) * $signed(weight_i);
    prod_ext = ExtW'(prod);
    sum      = ExtW'(acc_q) + prod_ext;
    acc_d    = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = sum[ACC_WIDTH-1:0];
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/window_mac.sv
// Window multiply-accumulate: streams K*K pixels per lane against a row-major weight store
// and presents one accumulated result per lane through a valid/ready handshake.
module window_mac
  import window_mac_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned IMAGE_WIDTH = 8,
  parameter int unsigned NUM_UNITS   = 2,
  parameter int unsigned ACC_WIDTH   = 40
) (
  input  logic       clk,
  input  logic       reset,
  window_mac_if.slave bus
);

  localparam int unsigned KW    = kdim_width(IMAGE_WIDTH);
  localparam int unsigned TW    = tap_width(IMAGE_WIDTH);
  localparam int unsigned Depth = IMAGE_WIDTH * IMAGE_WIDTH;

  state_e                              state_q, state_d;
  logic [KW-1:0]                       kdim_q, kdim_d;
  logic [TW-1:0]                       tap_q, tap_d;
  logic                                done_q, done_d;
  logic [TW-1:0]                       last_tap;
  logic                                start_ok, clear, beat, last_beat, xfer;
  logic [DATA_WIDTH-1:0]               w_mem [Depth];
  logic [DATA_WIDTH-1:0]               cur_w;
  logic [NUM_UNITS-1:0][ACC_WIDTH-1:0] acc;

  // A zero-sized kernel is not a legal request and is ignored.
  assign start_ok  = bus.start && (bus.kernel_dim != '0);
  assign clear     = (state_q == StIdle) && start_ok;
  assign beat      = (state_q == StAccum) && bus.in_valid;
  assign last_tap  = TW'(kdim_q) * TW'(kdim_q) - TW'(1);
  assign last_beat = beat && (tap_q == last_tap);
  assign xfer      = (state_q == StHold) && bus.out_ready;
  assign cur_w     = w_mem[tap_q];

  // State, kernel size, tap counter and completion pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      kdim_q  <= '0;
      tap_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kdim_q  <= kdim_d;
      tap_q   <= tap_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_ok)  state_d = StAccum;
      StAccum: if (last_beat) state_d = StHold;
      StHold:  if (xfer)      state_d = StIdle;
      default:                state_d = StIdle;
    endcase
  end

  // Kernel latch, tap advance and done generation.
  always_comb begin
    kdim_d = kdim_q;
    tap_d  = tap_q;
    done_d = xfer;
    if (clear) begin
      kdim_d = bus.kernel_dim;
      tap_d  = '0;
    end else if (beat) begin
      tap_d = tap_q + TW'(1);
    end
  end

  // Outputs decoded from state; the result is the live accumulator, frozen in HOLD.
  always_comb begin
    bus.step      = (state_q == StAccum);
    bus.busy      = (state_q != StIdle);
    bus.out_valid = (state_q == StHold);
    bus.done      = done_q;
    bus.out_data  = acc;
  end

  // Weight store: writable only while idle, deliberately not reset.
  always_ff @(posedge clk) begin
    if (bus.w_we && (state_q == StIdle)) begin
      w_mem[bus.w_addr] <= bus.w_data;
    end
  end

  for (genvar i = 0; i < NUM_UNITS; i++) begin : g_lane
    mac_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .ACC_WIDTH (ACC_WIDTH)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .clear_i (clear),
      .en_i    (beat),
      .pixel_i (bus.in_data[i]),
      .weight_i(cur_w),
      .acc_o   (acc[i])
    );
  end

endmodule

// File: tb/tb_window_mac.sv
module tb_window_mac;
  import window_mac_pkg::*;

  localparam int DW  = 16;
  localparam int IW  = 8;
  localparam int NU  = 2;
  localparam int AW  = 40;
  localparam int AW8 = 8;
  localparam int KW  = 3;
  localparam int TW  = 6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  window_mac_if #(.DATA_WIDTH(DW), .IMAGE_WIDTH(IW), .NUM_UNITS(NU), .ACC_WIDTH(AW)) bus ();
  window_mac_if #(.DATA_WIDTH(DW), .IMAGE_WIDTH(IW), .NUM_UNITS(NU), .ACC_WIDTH(AW8)) bus8 ();

  window_mac #(.DATA_WIDTH(DW), .IMAGE_WIDTH(IW), .NUM_UNITS(NU), .ACC_WIDTH(AW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  window_mac #(.DATA_WIDTH(DW), .IMAGE_WIDTH(IW), .NUM_UNITS(NU), .ACC_WIDTH(AW8)) dut8 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus8)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference state: weight store contents and per-lane pixel streams.
  int wm    [64];
  int beat0 [64];
  int beat1 [64];

  function automatic int rand_s16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  // Dot product of the first k*k stream entries with the weights, wrapped to AW bits.
  function automatic logic [AW-1:0] model(input int k, input int lane);
    longint s = 0;
    for (int t = 0; t < k * k; t++) begin
      s += longint'(lane == 0 ? beat0[t] : beat1[t]) * longint'(wm[t]);
    end
    return s[AW-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_w(input int a, input int d);
    bus.w_we   = 1'b1;
    bus.w_addr = TW'(a);
    bus.w_data = DW'(d);
    tick();
    bus.w_we   = 1'b0;
  endtask

  task automatic load_random(input int k);
    for (int t = 0; t < k * k; t++) begin
      wm[t]    = rand_s16();
      beat0[t] = rand_s16();
      beat1[t] = rand_s16();
      write_w(t, wm[t]);
    end
  endtask

  task automatic start_run(input int k);
    bus.kernel_dim = KW'(k);
    bus.start      = 1'b1;
    tick();
    bus.start      = 1'b0;
  endtask

  // mode 0: every cycle valid, 1: every other cycle, 2: random gaps. Junk data when invalid.
  task automatic feed(input int k, input int mode, output bit step_low, output bit to);
    int i   = 0;
    int cyc = 0;
    bit v;
    step_low = 1'b0;
    to       = 1'b0;
    while (i < k * k) begin
      if (cyc > 2000) begin
        to = 1'b1;
        break;
      end
      v = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      bus.in_valid   = v;
      bus.in_data[0] = v ? DW'(beat0[i]) : DW'(rand_s16());
      bus.in_data[1] = v ? DW'(beat1[i]) : DW'(rand_s16());
      if (bus.step !== 1'b1) step_low = 1'b1;
      tick();
      if (v) i++;
      cyc++;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else n_pass++;
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", bus.out_valid); else n_pass++;
    n_total++; if (bus.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done); else n_pass++;
    n_total++; if (bus.step !== 1'b0) $display("FAIL reset_step got %b want 0", bus.step); else n_pass++;
    n_total++; if (bus.out_data !== '0) $display("FAIL reset_out_data got %h want 0", bus.out_data); else n_pass++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_directed_k2();
    bit sl, to;
    int w [4] = '{1, 2, 3, 4};
    int l1 [4] = '{2, 0, -1, 3};
    for (int t = 0; t < 4; t++) begin
      wm[t] = w[t]; beat0[t] = 1; beat1[t] = l1[t];
      write_w(t, w[t]);
    end
    start_run(2);
    n_total++; if (bus.busy !== 1'b1) $display("FAIL k2_busy got %b want 1", bus.busy); else n_pass++;
    feed(2, 0, sl, to);
    n_total++; if (bus.out_valid !== 1'b1) $display("FAIL k2_out_valid got %b want 1", bus.out_valid); else n_pass++;
    n_total++; if (bus.out_data[0] !== AW'(10)) $display("FAIL k2_lane0 got %0d want 10", bus.out_data[0]); else n_pass++;
    n_total++; if (bus.out_data[1] !== AW'(11)) $display("FAIL k2_lane1 got %0d want 11", bus.out_data[1]); else n_pass++;
    n_total++; if (bus.step !== 1'b0) $display("FAIL k2_step_hold got %b want 0", bus.step); else n_pass++;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL k2_valid_after got %b want 0", bus.out_valid); else n_pass++;
    n_total++; if (bus.done !== 1'b1) $display("FAIL k2_done got %b want 1", bus.done); else n_pass++;
    tick();
    n_total++; if (bus.done !== 1'b0) $display("FAIL k2_done_width got %b want 0", bus.done); else n_pass++;
  endtask

  task automatic test_gapped_k3();
    bit sl, to;
    for (int t = 0; t < 9; t++) begin
      wm[t] = 1; beat0[t] = 5; beat1[t] = 5;
      write_w(t, 1);
    end
    start_run(3);
    feed(3, 1, sl, to);
    n_total++; if (to) $display("FAIL k3_timeout got 1 want 0"); else n_pass++;
    n_total++; if (sl) $display("FAIL k3_step_low got 1 want 0"); else n_pass++;
    n_total++; if (bus.out_valid !== 1'b1) $display("FAIL k3_out_valid got %b want 1", bus.out_valid); else n_pass++;
    n_total++; if (bus.out_data[0] !== AW'(45)) $display("FAIL k3_lane0 got %0d want 45", bus.out_data[0]); else n_pass++;
    n_total++; if (bus.out_data[1] !== AW'(45)) $display("FAIL k3_lane1 got %0d want 45", bus.out_data[1]); else n_pass++;
    drain();
  endtask

  task automatic test_hold_stall();
    bit sl, to;
    logic [AW-1:0] e0, e1;
    load_random(3);
    e0 = model(3, 0);
    e1 = model(3, 1);
    start_run(3);
    feed(3, 2, sl, to);
    for (int c = 0; c < 5; c++) begin
      n_total++;
      if (bus.out_valid !== 1'b1 || bus.out_data[0] !== e0 || bus.out_data[1] !== e1 || bus.done !== 1'b0)
        $display("FAIL hold_stable c=%0d got v=%b d0=%h d1=%h done=%b want v=1 d0=%h d1=%h done=0",
                 c, bus.out_valid, bus.out_data[0], bus.out_data[1], bus.done, e0, e1);
      else n_pass++;
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    n_total++; if (bus.done !== 1'b1) $display("FAIL hold_done got %b want 1", bus.done); else n_pass++;
    tick();
    n_total++; if (bus.done !== 1'b0) $display("FAIL hold_done_once got %b want 0", bus.done); else n_pass++;
  endtask

  task automatic test_ignored();
    bit sl, to;
    logic [AW-1:0] e0, e1;
    bus.out_ready = 1'b1;
    tick();
    tick();
    bus.out_ready = 1'b0;
    n_total++; if (bus.done !== 1'b0 || bus.out_valid !== 1'b0)
      $display("FAIL idle_ready got done=%b v=%b want 0 0", bus.done, bus.out_valid); else n_pass++;
    start_run(0);
    n_total++; if (bus.busy !== 1'b0) $display("FAIL start_k0 got busy=%b want 0", bus.busy); else n_pass++;
    load_random(2);
    e0 = model(2, 0);
    e1 = model(2, 1);
    start_run(2);
    // Restart with a larger kernel and a weight overwrite mid-run: both must be dropped.
    bus.start = 1'b1; bus.kernel_dim = KW'(3);
    bus.w_we = 1'b1; bus.w_addr = '0; bus.w_data = DW'(wm[0] + 1);
    tick();
    bus.start = 1'b0; bus.w_we = 1'b0;
    feed(2, 0, sl, to);
    n_total++; if (bus.out_valid !== 1'b1) $display("FAIL ign_valid got %b want 1", bus.out_valid); else n_pass++;
    n_total++; if (bus.out_data[0] !== e0 || bus.out_data[1] !== e1)
      $display("FAIL ign_result got %h %h want %h %h", bus.out_data[0], bus.out_data[1], e0, e1); else n_pass++;
    // Write in HOLD is also dropped.
    write_w(1, wm[1] + 7);
    drain();
    start_run(2);
    feed(2, 2, sl, to);
    n_total++; if (bus.out_data[0] !== e0 || bus.out_data[1] !== e1)
      $display("FAIL ign_hold_write got %h %h want %h %h", bus.out_data[0], bus.out_data[1], e0, e1); else n_pass++;
    drain();
  endtask

  task automatic test_reset_mid();
    bit sl, to, saw_done;
    logic [AW-1:0] e0, e1;
    load_random(2);
    start_run(2);
    bus.in_valid = 1'b1; bus.in_data[0] = DW'(beat0[0]); bus.in_data[1] = DW'(beat1[0]);
    tick();
    bus.in_data[0] = DW'(beat0[1]); bus.in_data[1] = DW'(beat1[1]);
    tick();
    bus.in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    n_total++; if (bus.busy !== 1'b0 || bus.step !== 1'b0 || bus.out_data !== '0)
      $display("FAIL mid_reset got busy=%b step=%b data=%h want 0 0 0", bus.busy, bus.step, bus.out_data);
    else n_pass++;
    tick();
    reset = 1'b0;
    saw_done = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (bus.done !== 1'b0) saw_done = 1'b1;
      tick();
    end
    n_total++; if (saw_done) $display("FAIL mid_reset_done got 1 want 0"); else n_pass++;
    // Weights survive reset; only the streams change.
    for (int t = 0; t < 4; t++) begin beat0[t] = rand_s16(); beat1[t] = rand_s16(); end
    e0 = model(2, 0);
    e1 = model(2, 1);
    start_run(2);
    feed(2, 2, sl, to);
    n_total++; if (bus.out_data[0] !== e0 || bus.out_data[1] !== e1)
      $display("FAIL mid_reset_rerun got %h %h want %h %h", bus.out_data[0], bus.out_data[1], e0, e1);
    else n_pass++;
    drain();
  endtask

  task automatic test_random();
    bit sl, to;
    int k;
    logic [AW-1:0] e0, e1;
    for (int it = 0; it < 8; it++) begin
      k = $urandom_range(1, 7);
      load_random(k);
      e0 = model(k, 0);
      e1 = model(k, 1);
      start_run(k);
      feed(k, 2, sl, to);
      n_total++;
      if (to || sl || bus.out_valid !== 1'b1 || bus.out_data[0] !== e0 || bus.out_data[1] !== e1)
        $display("FAIL rand k=%0d got to=%b sl=%b v=%b %h %h want 0 0 1 %h %h",
                 k, to, sl, bus.out_valid, bus.out_data[0], bus.out_data[1], e0, e1);
      else n_pass++;
      repeat ($urandom_range(0, 3)) tick();
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      n_total++; if (bus.done !== 1'b1) $display("FAIL rand_done k=%0d got %b want 1", k, bus.done); else n_pass++;
      tick();
    end
  endtask

  task automatic test_acc8();
    for (int t = 0; t < 4; t++) begin
      bus8.w_we = 1'b1; bus8.w_addr = TW'(t); bus8.w_data = DW'(127);
      tick();
    end
    bus8.w_we = 1'b0;
    bus8.kernel_dim = KW'(2); bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    bus8.in_valid = 1'b1; bus8.in_data[0] = DW'(127); bus8.in_data[1] = DW'(127);
    repeat (4) tick();
    bus8.in_valid = 1'b0;
    n_total++; if (bus8.out_valid !== 1'b1) $display("FAIL acc8_valid got %b want 1", bus8.out_valid); else n_pass++;
    n_total++; if (bus8.out_data[0] !== 8'd4 || bus8.out_data[1] !== 8'd4)
      $display("FAIL acc8_wrap got %0d %0d want 4 4", bus8.out_data[0], bus8.out_data[1]); else n_pass++;
    bus8.out_ready = 1'b1;
    tick();
    bus8.out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;  bus.kernel_dim = '0; bus.w_we = 1'b0;  bus.w_addr = '0; bus.w_data = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    bus8.start = 1'b0; bus8.kernel_dim = '0; bus8.w_we = 1'b0; bus8.w_addr = '0; bus8.w_data = '0;
    bus8.in_valid = 1'b0; bus8.in_data = '0; bus8.out_ready = 1'b0;
    test_reset();
    test_directed_k2();
    test_gapped_k3();
    test_hold_stall();
    test_ignored();
    test_reset_mid();
    test_random();
    test_acc8();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
